snax_tcdm_responder: RTL and testbench
======================================

# snax_tcdm_responder

Multi-port TCDM responder that serves the tightly-coupled data memory request/response interface driven by SNAX accelerators. Each port accepts one request per cycle, routes it to one of `NumBanks` word-interleaved SRAM banks, arbitrates bank conflicts round-robin with `q_ready` back-pressure, and returns read data one cycle after grant. It is the memory-side end of the accelerator TCDM ports. It serves as the cluster-level memory model for standalone accelerator testbenches, and as the bank front-end in reduced clusters.

## Interface
- `DataWidth`, 64: word width in bits; byte strobe width `DataWidth/8`.
- `NumPorts`, 16: number of requester ports.
- `NumBanks`, 32: number of interleaved banks; power of two, ≥ 1.
- `BankWords`, 256: words per bank; power of two.
- `AddrWidth`, 17: byte-address width of `q.addr`.
- `tcdm_req_t`, logic: request struct with `q_valid`, `q.addr`, `q.write`, `q.amo`, `q.data`, `q.strb`, `q.user`.
- `tcdm_rsp_t`, logic: response struct with `q_ready`, `p_valid`, `p.data`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tcdm_req_i`  in  `NumPorts` × `tcdm_req_t`  per-port requests.
- `tcdm_rsp_o`  out  `NumPorts` × `tcdm_rsp_t`  per-port ready and responses.
- `conflict_cnt_o`  out  32  saturating count of cycles with at least one stalled request.

## Operation
- Address decode per port:
  - `word = q.addr[AddrWidth-1:log2(DataWidth/8)]`.
  - `bank = word mod NumBanks`.
  - `row = (word / NumBanks) mod BankWords`.
  - Address bits above the row field are ignored, so addresses wrap.
- Arbitration, per bank:
  - The candidates are the ports with `q_valid=1` that decode to that bank.
  - Exactly one candidate is granted, chosen round-robin from the bank's pointer.
  - The pointer resets to 0.
  - After a grant the pointer becomes `(winner+1) mod NumPorts`.
  - With no candidates, the pointer holds.
- `q_ready` is 1 only for a granted port, and is 0 whenever `q_valid=0`.
- A stalled port must hold its request stable until granted. The responder does not check this.
- Granted write (`q.write=1`):
  - Each byte `k` of the row is updated from `q.data` where `q.strb[k]=1`.
  - Other bytes are unchanged.
  - No response is generated.
- Granted read (`q.write=0`):
  - The row is read; `p_valid=1` on that port the next cycle, with `p.data` equal to the row contents.
- `q.amo` and `q.user` are ignored; every request is treated as a plain load or store.
- `p.data` is 0 whenever `p_valid=0`.
- Each port has at most one response in flight: one grant per cycle gives one response per cycle.
- `conflict_cnt_o`:
  - Increments by 1 in any cycle where some port has `q_valid=1` and `q_ready=0`.
  - Saturates at `32'hFFFF_FFFF`.
- Bank contents are not reset; they are undefined until written.

## Timing
- Reset (`rst_i=1` at an edge) clears:
  - all `p_valid`, so `p.data` reads 0;
  - all round-robin pointers to 0;
  - `conflict_cnt_o` to 0.
- While `rst_i=1`, all `q_ready=0`, no bank is written, and no grant is made.
- Reset mid-operation: a read granted in the cycle before reset has its response dropped. `p_valid=0` in the cycle after the reset edge.
- `q_ready` is combinational from the same-cycle `q_valid` and `q.addr`. There is no register between request and grant.
- Read latency is exactly 1 cycle: granted at cycle T gives `p_valid` at T+1 for that single cycle.
- Write takes effect at the grant edge. A read of the same row granted at T+1 returns the new data at T+2.
- Back-to-back reads on one port with no conflict: one grant per cycle and one `p_valid` per cycle, at full throughput.
- Simultaneous requests to distinct banks are all granted in the same cycle.
- Simultaneous requests to the same bank are serialized: n requesters finish in n cycles.
- The data path is independent per port: a stall on port i never delays a response already in flight on port j.

## Test plan
- Reset:
  - Stimulus: hold `rst_i=1` for 2 cycles with all 16 ports driving `q_valid=1`.
  - Required: all `q_ready=0`, all `p_valid=0`, `conflict_cnt_o=0`.
  - After release, every port is granted within 1 cycle, because the addresses are chosen to hit distinct banks.
- Parallel write then read:
  - Port i writes `64'hA5A5_0000_0000_0000+i` to `addr=i*8` with full strobe.
  - The next cycle, port i reads `addr=i*8`.
  - Required: the write is granted to all ports in 1 cycle, and `p_valid` is seen on all ports 1 cycle after the read with matching data.
- Byte strobes:
  - Write `64'hFFFF_FFFF_FFFF_FFFF` to `0x100`, then write `64'h0` with `strb=8'h0F`, then read.
  - Required: the read returns `64'hFFFF_FFFF_0000_0000`.
- Bank conflict:
  - Ports 0, 3 and 7 read `0x000`, `0x100` and `0x200`, all in bank 0 (`NumBanks=32`), held valid.
  - Required: grants go to ports 0, 3 and 7 in consecutive cycles.
  - `conflict_cnt_o` increments by 2.
  - The next contention on bank 0 starts at port 8.
- Address wrap:
  - Write `64'h1234` to `addr=0`, then read `addr=NumBanks*BankWords*8` (`0x10000`).
  - Required: the read returns `64'h1234`.
- Reset mid-read:
  - Grant a read at cycle T and assert `rst_i` at T+1.
  - Required: `p_valid=0` at T+1.

Source files
------------

// File: rtl/snax_tcdm_responder.sv
// Multi-port, multi-bank TCDM memory model. Word-interleaved banks, round-robin
// arbitration per bank, one-cycle read latency.

package snax_tcdm_pkg;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned AddrWidth = 17;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [3:0]           amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    tcdm_rsp_chan_t p;
    logic           p_valid;
    logic           q_ready;
  } tcdm_rsp_t;

endpackage

module snax_tcdm_responder #(
  parameter int unsigned DataWidth = snax_tcdm_pkg::DataWidth,
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned NumBanks  = 32,
  parameter int unsigned BankWords = 256,
  parameter int unsigned AddrWidth = snax_tcdm_pkg::AddrWidth,
  parameter type tcdm_req_t = snax_tcdm_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = snax_tcdm_pkg::tcdm_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  tcdm_req_t [NumPorts-1:0] tcdm_req_i,
  output tcdm_rsp_t [NumPorts-1:0] tcdm_rsp_o,
  output logic [31:0]              conflict_cnt_o
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned ByteOffBits = $clog2(StrbWidth);
  localparam int unsigned BankBits    = $clog2(NumBanks);
  localparam int unsigned RowBits     = $clog2(BankWords);
  localparam int unsigned BankIdxW    = (BankBits > 0) ? BankBits : 1;
  localparam int unsigned RowIdxW     = (RowBits > 0) ? RowBits : 1;
  localparam int unsigned PortIdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef logic [BankIdxW-1:0] bank_idx_t;
  typedef logic [RowIdxW-1:0]  row_idx_t;
  typedef logic [PortIdxW-1:0] port_idx_t;

  // Per-port decode
  logic [NumPorts-1:0]  port_valid;
  logic [AddrWidth-1:0] port_word [NumPorts];
  bank_idx_t            port_bank [NumPorts];
  row_idx_t             port_row  [NumPorts];
  logic                 unused_req_fields;

  // Per-bank arbitration
  logic [NumPorts-1:0]  bank_cand [NumBanks];
  logic [NumBanks-1:0]  bank_gnt;
  port_idx_t            bank_win  [NumBanks];
  port_idx_t            rr_ptr_q  [NumBanks];
  port_idx_t            rr_ptr_d  [NumBanks];
  logic [NumPorts-1:0]  port_gnt;

  // Per-bank access selected from the winner
  logic [NumBanks-1:0]  bank_we;
  logic [NumBanks-1:0]  bank_re;
  row_idx_t             bank_row   [NumBanks];
  logic [DataWidth-1:0] bank_wdata [NumBanks];
  logic [StrbWidth-1:0] bank_strb  [NumBanks];

  // Storage and response state
  logic [DataWidth-1:0] mem_q        [NumBanks][BankWords];
  logic [DataWidth-1:0] bank_rdata_q [NumBanks];
  logic [NumPorts-1:0]  p_valid_q, p_valid_d;
  bank_idx_t            rsp_bank_q [NumPorts];
  bank_idx_t            rsp_bank_d [NumPorts];
  logic [31:0]          conflict_cnt_q, conflict_cnt_d;
  logic                 stall;

  // Split each byte address into bank and row; high bits above the row wrap.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      port_valid[p] = tcdm_req_i[p].q_valid;
      port_word[p]  = AddrWidth'(tcdm_req_i[p].q.addr >> ByteOffBits);
      port_bank[p]  = (NumBanks > 1) ? bank_idx_t'(port_word[p]) : '0;
      port_row[p]   = (BankWords > 1) ? row_idx_t'(port_word[p] >> BankBits) : '0;
    end
  end

  // Request fields this responder deliberately ignores (atomics, user bits).
  always_comb begin
    unused_req_fields = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      unused_req_fields = unused_req_fields ^
                          (^{tcdm_req_i[p].q.amo, tcdm_req_i[p].q.user, port_word[p]});
    end
  end

  // Round-robin pick per bank, scanning upward from the bank's pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    int unsigned idx;
    port_idx_t   cand_idx;
    idx      = 0;
    cand_idx = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_cand[b] = '0;
      bank_gnt[b]  = 1'b0;
      bank_win[b]  = '0;
      rr_ptr_d[b]  = rr_ptr_q[b];
      for (int p = 0; p < NumPorts; p++) begin
        bank_cand[b][p] = port_valid[p] && !rst_i && (port_bank[p] == bank_idx_t'(b));
      end
      for (int off = 0; off < NumPorts; off++) begin
        idx = int'(rr_ptr_q[b]) + off;
        if (idx >= NumPorts) idx = idx - NumPorts;
        cand_idx = port_idx_t'(idx);
        if (!bank_gnt[b] && bank_cand[b][cand_idx]) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = cand_idx;
        end
      end
      if (bank_gnt[b]) begin
        rr_ptr_d[b] = (bank_win[b] == port_idx_t'(NumPorts - 1)) ? '0
                                                                 : bank_win[b] + port_idx_t'(1);
      end
    end
  end

  // Fold bank grants back onto ports and steer the winner's request into its bank.
  always_comb begin
    port_gnt = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_row[b]   = port_row[bank_win[b]];
      bank_wdata[b] = tcdm_req_i[bank_win[b]].q.data;
      bank_strb[b]  = tcdm_req_i[bank_win[b]].q.strb;
      bank_we[b]    = bank_gnt[b] && tcdm_req_i[bank_win[b]].q.write;
      bank_re[b]    = bank_gnt[b] && !tcdm_req_i[bank_win[b]].q.write;
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[b] && (bank_win[b] == port_idx_t'(p))) port_gnt[p] = 1'b1;
      end
    end
  end

  // Response bookkeeping and the stall counter.
  always_comb begin
    stall = |(port_valid & ~port_gnt);
    for (int p = 0; p < NumPorts; p++) begin
      p_valid_d[p]  = port_gnt[p] && !tcdm_req_i[p].q.write;
      rsp_bank_d[p] = port_bank[p];
    end
    conflict_cnt_d = (stall && (conflict_cnt_q != 32'hFFFF_FFFF)) ? conflict_cnt_q + 32'd1
                                                                    : conflict_cnt_q;
  end

  // Control state: pointers, response valids, stall counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      p_valid_q      <= '0;
      conflict_cnt_q <= '0;
      for (int b = 0; b < NumBanks; b++) rr_ptr_q[b] <= '0;
      for (int p = 0; p < NumPorts; p++) rsp_bank_q[p] <= '0;
    end else begin
      p_valid_q      <= p_valid_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int b = 0; b < NumBanks; b++) rr_ptr_q[b] <= rr_ptr_d[b];
      for (int p = 0; p < NumPorts; p++) rsp_bank_q[p] <= rsp_bank_d[p];
    end
  end

  // Bank arrays: byte-strobed write and registered read, one access per bank per cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is never reset; grants are already blocked during reset, and p_valid guards stale read data.
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_we[b]) begin
        for (int k = 0; k < StrbWidth; k++) begin
          if (bank_strb[b][k]) mem_q[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
        end
      end
      if (bank_re[b]) bank_rdata_q[b] <= mem_q[b][bank_row[b]];
    end
  end

  // Drive ready and responses; reset masks an in-flight response immediately.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      tcdm_rsp_o[p]         = '0;
      tcdm_rsp_o[p].q_ready = port_gnt[p];
      tcdm_rsp_o[p].p_valid = p_valid_q[p] && !rst_i;
      if (p_valid_q[p] && !rst_i) tcdm_rsp_o[p].p.data = bank_rdata_q[rsp_bank_q[p]];
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Directed bench for snax_tcdm_responder. Stimulus pushes expected read data
// into per-port queues; a negedge monitor pops and compares every response.

module tb_snax_tcdm_responder;
  import snax_tcdm_pkg::*;

  localparam int NP = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  tcdm_req_t [NP-1:0]   req;
  tcdm_rsp_t [NP-1:0]   rsp;
  logic [31:0]          cnt;

  snax_tcdm_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm_req_i     (req),
    .tcdm_rsp_o     (rsp),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t        sb [NP][$];
  logic [63:0] exp_rd [NP];
  bit          mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every cycle, each port either delivers its due response or stays idle with zero data.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        if (sb[p].size() > 0 && sb[p][0].due == cyc) begin
          check($sformatf("p_valid[%0d]", p), 64'(rsp[p].p_valid), 64'd1);
          check($sformatf("p_data[%0d]", p), rsp[p].p.data, sb[p][0].data);
          void'(sb[p].pop_front());
        end else begin
          check($sformatf("idle_valid[%0d]", p), 64'(rsp[p].p_valid), 64'd0);
          check($sformatf("idle_data[%0d]", p), rsp[p].p.data, 64'd0);
        end
      end
    end
  end

  task automatic clr();
    for (int p = 0; p < NP; p++) req[p] = '0;
  endtask

  task automatic rd(input int p, input logic [16:0] a, input logic [63:0] d);
    req[p]           = '0;
    req[p].q_valid   = 1'b1;
    req[p].q.addr    = a;
    req[p].q.write   = 1'b0;
    exp_rd[p]        = d;
  endtask

  task automatic wr(input int p, input logic [16:0] a, input logic [63:0] d, input logic [7:0] s);
    req[p]           = '0;
    req[p].q_valid   = 1'b1;
    req[p].q.addr    = a;
    req[p].q.write   = 1'b1;
    req[p].q.data    = d;
    req[p].q.strb    = s;
  endtask

  // Called at posedge+1 with inputs set: check ready, queue expected reads, advance one cycle.
  task automatic issue(input logic [NP-1:0] exp_rdy, input string name, input bit push_rd = 1'b1);
    logic [NP-1:0] got;
    exp_t          e;
    #1;
    for (int p = 0; p < NP; p++) got[p] = rsp[p].q_ready;
    check(name, 64'(got), 64'(exp_rdy));
    for (int p = 0; p < NP; p++) begin
      if (push_rd && exp_rdy[p] && req[p].q_valid && !req[p].q.write) begin
        e.due  = cyc + 1;
        e.data = exp_rd[p];
        sb[p].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    check("cnt_reset", 64'(cnt), 64'd0);

    // Reset held with all ports requesting distinct banks: nothing granted.
    for (int p = 0; p < NP; p++) wr(p, 17'(p * 8), 64'hA5A5_0000_0000_0000 + 64'(p), 8'hFF);
    for (int i = 0; i < 2; i++) begin
      issue('0, "rst_ready");
      check("cnt_in_reset", 64'(cnt), 64'd0);
    end

    // Release: all parallel writes granted at once, then all reads.
    rst = 1'b0;
    issue('1, "par_wr_ready");
    for (int p = 0; p < NP; p++) rd(p, 17'(p * 8), 64'hA5A5_0000_0000_0000 + 64'(p));
    issue('1, "par_rd_ready");
    clr();
    issue('0, "idle_ready");
    check("cnt_no_conflict", 64'(cnt), 64'd0);

    // Byte strobes on 0x100 (bank 0, row 1).
    wr(5, 17'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    issue(16'h0020, "strb_wr_full");
    wr(5, 17'h100, 64'h0, 8'h0F);
    issue(16'h0020, "strb_wr_low");
    rd(5, 17'h100, 64'hFFFF_FFFF_0000_0000);
    issue(16'h0020, "strb_rd");
    clr();
    issue('0, "strb_idle");

    // Address wrap: 0x10000 aliases address 0.
    wr(2, 17'h0, 64'h1234, 8'hFF);
    issue(16'h0004, "wrap_wr");
    rd(2, 17'h10000, 64'h1234);
    issue(16'h0004, "wrap_rd");
    clr();
    wr(7, 17'h200, 64'hC0FF_EE00_0000_0007, 8'hFF);
    issue(16'h0080, "prep_wr");
    clr();

    // Reset the cycle after a read grant: the response must vanish.
    rd(4, 17'h20, 64'hA5A5_0000_0000_0004);
    issue(16'h0010, "mid_rd_ready", 1'b0);
    rst = 1'b1;
    clr();
    issue('0, "mid_rst_ready");
    rst = 1'b0;
    check("cnt_after_mid_rst", 64'(cnt), 64'd0);

    // Three ports on bank 0 with pointer at 0: grants 0, 3, 7 in order.
    rd(0, 17'h000, 64'h1234);
    rd(3, 17'h100, 64'hFFFF_FFFF_0000_0000);
    rd(7, 17'h200, 64'hC0FF_EE00_0000_0007);
    issue(16'h0001, "conf_gnt0");
    req[0] = '0;
    check("conf_cnt1", 64'(cnt), 64'd1);
    issue(16'h0008, "conf_gnt3");
    req[3] = '0;
    check("conf_cnt2", 64'(cnt), 64'd2);
    issue(16'h0080, "conf_gnt7");
    req[7] = '0;
    check("conf_cnt_hold", 64'(cnt), 64'd2);

    // Pointer now at 8: port 8 beats port 1.
    rd(1, 17'h000, 64'h1234);
    rd(8, 17'h100, 64'hFFFF_FFFF_0000_0000);
    issue(16'h0100, "rr_gnt8");
    req[8] = '0;
    check("rr_cnt3", 64'(cnt), 64'd3);
    issue(16'h0002, "rr_gnt1");
    clr();
    check("rr_cnt_hold", 64'(cnt), 64'd3);
    issue('0, "drain_idle0");
    issue('0, "drain_idle1");

    mon_en = 1'b0;
    for (int p = 0; p < NP; p++) check($sformatf("drain[%0d]", p), 64'(sb[p].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
